// File: rtl/uart_rx_if.sv
// Byte-side and serial-side signals of the 8N1 UART receiver.
// The receiver takes the slave modport; the upstream/downstream environment takes the master modport.
interface uart_rx_if;
  logic       rx;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;

  modport master (
    output rx, ready,
    input  data, valid, frame_err, overrun
  );

  modport slave (
    input  rx, ready,
    output data, valid, frame_err, overrun
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling FSM and a one-deep
// holding register with valid/ready hand-off, frame-error and overrun pulses.
module uart_rx #(
  parameter int CLKS_PER_BIT = 25,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input logic      clk,
  input logic      rst,
  uart_rx_if.slave bus
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_nxt;
  logic             sync_p0, sync_p1;
  logic             rx_s;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shift;
  logic             tick;
  logic             cnt_clr, idx_clr, shift_en, deliver, stop_bad;
  logic [7:0]       data_p0;
  logic             vld_p0, ferr_p0, ovr_p0;
  logic             slot_free, accept;

  assign rx_s = sync_p1;
  // START waits half a bit to land mid start-bit; the other states wait a full bit.
  assign tick = (state == START) ? (cnt == CNT_HALF) : (cnt == CNT_FULL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!rx_s) state_nxt = START;
      START:   if (tick) state_nxt = rx_s ? IDLE : DATA;
      DATA:    if (tick && idx == 3'd7) state_nxt = STOP;
      STOP:    if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cnt_clr  = 1'b0;
    idx_clr  = 1'b0;
    shift_en = 1'b0;
    deliver  = 1'b0;
    stop_bad = 1'b0;
    case (state)
      IDLE:  cnt_clr = 1'b1;
      START: begin
        cnt_clr = tick;
        idx_clr = tick;
      end
      DATA: begin
        cnt_clr  = tick;
        shift_en = tick;
      end
      STOP: begin
        cnt_clr  = tick;
        deliver  = tick & rx_s;
        stop_bad = tick & ~rx_s;
      end
      default: cnt_clr = 1'b1;
    endcase
  end

  // Stage p0/p1: line synchroniser feeding the bit sampler
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      cnt     <= '0;
      idx     <= '0;
      shift   <= '0;
    end else begin
      sync_p0 <= bus.rx;
      sync_p1 <= sync_p0;
      cnt     <= cnt_clr ? '0 : cnt + 1'b1;
      if (idx_clr)       idx <= 3'd0;
      else if (shift_en) idx <= idx + 3'd1;
      if (shift_en) shift <= {rx_s, shift[7:1]};
    end
  end

  // An accept in the same cycle as a delivery frees the slot for the new byte.
  assign accept    = vld_p0 & bus.ready;
  assign slot_free = ~vld_p0 | bus.ready;

  // Stage p0 output: holding register and status pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_p0 <= '0;
      vld_p0  <= 1'b0;
      ferr_p0 <= 1'b0;
      ovr_p0  <= 1'b0;
    end else begin
      if (deliver && slot_free) begin
        data_p0 <= shift;
        vld_p0  <= 1'b1;
      end else if (accept) begin
        vld_p0  <= 1'b0;
      end
      ferr_p0 <= stop_bad;
      ovr_p0  <= deliver & ~slot_free;
    end
  end

  assign bus.data      = data_p0;
  assign bus.valid     = vld_p0;
  assign bus.frame_err = ferr_p0;
  assign bus.overrun   = ovr_p0;

endmodule
